// File: rtl/gzip_out_byte_serializer.sv
// gzip_out_byte_serializer: pops 32-bit Deflate FIFO words and streams them out one byte per cycle.
// Define OUT_BYTE_CNT_EN to build the emitted-byte counter on out_byte_cnt.
module gzip_out_byte_serializer #(
    parameter int LSB_FIRST = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty_out_fifo,
    output logic                 rd_en_fifo_out,
    input  logic [31:0]          dout_out_fifo_32,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic [7:0]           byte_data,
    output logic                 busy,
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] out_byte_cnt
);
    logic [31:0] act_word, pre_word;
    logic [2:0]  act_left;
    logic        pre_valid, rd_pending, hs, last_hs, land_act;
    logic [1:0]  idx, sel;
    assign byte_valid = act_left != 3'd0;
    assign hs = byte_valid & byte_ready;
    assign last_hs = hs & (act_left == 3'd1);
    assign land_act = ((act_left == 3'd0) | last_hs) & ~pre_valid;
    assign rd_en_fifo_out = ~empty_out_fifo & ~rd_pending & ~pre_valid & ~(byte_valid & rd_pending);
    assign busy = rd_pending | byte_valid | pre_valid;
    assign idx = 2'(3'd4 - act_left);
    assign sel = LSB_FIRST != 0 ? idx : 2'd3 - idx;
    assign byte_data = byte_valid ? act_word[{sel, 3'b000} +: 8] : 8'h00;
    // A returning read lands in the active slot only when that slot is (or is becoming) empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_word <= '0;
            act_left <= '0;
            pre_word <= '0;
            pre_valid <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= rd_en_fifo_out;
            if (rd_pending && land_act) begin
                act_word <= dout_out_fifo_32;
                act_left <= 3'd4;
            end else if (last_hs && pre_valid) begin
                act_word <= pre_word;
                act_left <= 3'd4;
                pre_valid <= 1'b0;
            end else if (hs) begin
                act_left <= act_left - 3'd1;
            end
            if (rd_pending && !land_act) begin
                pre_word <= dout_out_fifo_32;
                pre_valid <= 1'b1;
            end
        end
    end
`ifdef OUT_BYTE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_byte_cnt <= '0;
        else if (clr_cnt) out_byte_cnt <= '0;
        else if (hs) out_byte_cnt <= out_byte_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign out_byte_cnt = '0;
`endif
endmodule

// File: tb/tb_gzip_out_byte_serializer.sv
// tb_gzip_out_byte_serializer: directed checks of byte order, throughput, stall, reset and counter.
module tb_gzip_out_byte_serializer;
    logic        clk = 1'b0, rst, ready, clr;
    logic        empty, rd0, rd1, bv0, bv1, busy0, busy1;
    logic [31:0] dout;
    logic [7:0]  bd0, bd1;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;
    logic [31:0] mem [0:63];
    int          wp = 0, rp = 0, vectors = 0, miscompares = 0, nrd;

    always #5 clk = ~clk;

    assign empty = (rp == wp);
    always @(posedge clk) if (rd0) begin
        dout <= mem[rp];
        rp <= rp + 1;
    end

    gzip_out_byte_serializer #(.LSB_FIRST(1), .CNT_WIDTH(32)) u0 (
        .clk(clk), .rst(rst), .empty_out_fifo(empty), .rd_en_fifo_out(rd0),
        .dout_out_fifo_32(dout), .byte_valid(bv0), .byte_ready(ready), .byte_data(bd0),
        .busy(busy0), .clr_cnt(clr), .out_byte_cnt(cnt0));
    gzip_out_byte_serializer #(.LSB_FIRST(0), .CNT_WIDTH(4)) u1 (
        .clk(clk), .rst(rst), .empty_out_fifo(empty), .rd_en_fifo_out(rd1),
        .dout_out_fifo_32(dout), .byte_valid(bv1), .byte_ready(ready), .byte_data(bd1),
        .busy(busy1), .clr_cnt(clr), .out_byte_cnt(cnt1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++)
            mem[wp+i] = {8'(base + 4*i + 3), 8'(base + 4*i + 2), 8'(base + 4*i + 1), 8'(base + 4*i)};
        wp = wp + n;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; clr = 1'b0;
        step(); step();
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_valid", 32'(bv0), 32'd0);
        chk("rst_data", 32'(bd0), 32'd0);
        chk("rst_rden", 32'(rd0), 32'd0);
        chk("rst_cnt", cnt0, 32'd0);
        rst = 1'b0;
        step();
        // single word, both byte orders
        ready = 1'b1;
        mem[wp] = 32'h44332211; wp = wp + 1;
        #1 chk("s1_rden_c0", 32'(rd0), 32'd1);
        chk("s1_rden1_c0", 32'(rd1), 32'd1);
        step();
        chk("s1_rden_c1", 32'(rd0), 32'd0);
        chk("s1_valid_c1", 32'(bv0), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("s1_valid", 32'(bv0), 32'd1);
            chk("s1_lsb", 32'(bd0), 32'(8'h11 * (k + 1)));
            chk("s1_msb", 32'(bd1), 32'(8'h11 * (4 - k)));
            step();
        end
        chk("s1_valid_end", 32'(bv0), 32'd0);
        chk("s1_busy_end", 32'(busy0), 32'd0);
        chk("s1_busy1_end", 32'(busy1), 32'd0);
        // eight words back to back
        clr = 1'b1; step(); clr = 1'b0;
        push(8'h01, 8);
        nrd = 0;
        for (int c = 0; c < 34; c++) begin
            if (c > 0) step();
            #1 if (rd0) nrd++;
            if (c >= 2) begin
                chk("s2_valid", 32'(bv0), 32'd1);
                chk("s2_data", 32'(bd0), 32'(8'(c - 1)));
            end
`ifdef OUT_BYTE_CNT_EN
            if (c == 17) chk("s2_cnt_pre_wrap", 32'(cnt1), 32'd15);
            if (c == 18) chk("s2_cnt_wrap", 32'(cnt1), 32'd0);
`endif
        end
        step();
        chk("s2_valid_end", 32'(bv0), 32'd0);
        chk("s2_reads", 32'(nrd), 32'd8);
`ifdef OUT_BYTE_CNT_EN
        chk("s2_cnt", cnt0, 32'd32);
`else
        chk("s2_cnt_off", cnt0, 32'd0);
        chk("s2_cnt1_off", 32'(cnt1), 32'd0);
`endif
        // backpressure with three words queued
        push(8'h81, 3);
        step(); step();
        chk("s3_b0", 32'(bd0), 32'h81);
        step();
        chk("s3_b1", 32'(bd0), 32'h82);
        step();
        ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1 chk("s3_hold_data", 32'(bd0), 32'h83);
            chk("s3_hold_valid", 32'(bv0), 32'd1);
            chk("s3_hold_rden", 32'(rd0), 32'd0);
            step();
        end
        ready = 1'b1; clr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1 chk("s3_resume", 32'(bd0), 32'(8'(8'h83 + k)));
            chk("s3_resume_valid", 32'(bv0), 32'd1);
            step();
            clr = 1'b0;
`ifdef OUT_BYTE_CNT_EN
            if (k == 0) chk("s3_clr_vs_inc", cnt0, 32'd0);
`endif
        end
        chk("s3_valid_end", 32'(bv0), 32'd0);
        chk("s3_busy_end", 32'(busy0), 32'd0);
        // async reset with active and prefetch slots full
        push(8'hC1, 2);
        step(); step(); step(); step();
        chk("s4_mid", 32'(bd0), 32'hC3);
        chk("s4_busy", 32'(busy0), 32'd1);
        ready = 1'b0;
        #2 rst = 1'b1;
        #1 chk("s4_rst_valid", 32'(bv0), 32'd0);
        chk("s4_rst_data", 32'(bd0), 32'd0);
        chk("s4_rst_busy", 32'(busy0), 32'd0);
        chk("s4_rst_rden", 32'(rd0), 32'd0);
        chk("s4_rst_cnt", cnt0, 32'd0);
        step();
        rst = 1'b0; ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s4_post_valid", 32'(bv0), 32'd0);
            chk("s4_post_busy", 32'(busy0), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
